// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Purpose : Valid/ready data-memory target with fixed access latency and
//           byte/half/word load-store on internal word storage.
// Rev     : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h01000000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT_LOAD  = 4'(LATENCY - 1);
    localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0]      offset_w;
    logic             in_range_w;
    logic             misalign_w;
    logic             err_w;
    logic [IDX_W-1:0] idx_w;
    logic [31:0]      rd_word_w;
    logic [7:0]       byte_w;
    logic [15:0]      half_w;
    logic [31:0]      load_w;
    logic [31:0]      lane_mask_w;
    logic [31:0]      merged_w;
    logic             access_w;
    logic             mem_we_w;

    // All address checks use the captured request; live inputs may already differ.
    assign offset_w   = addr_q - BASE_ADDR;
    assign in_range_w = (addr_q >= BASE_ADDR) && (offset_w < SPAN);
    assign misalign_w = ((size_q == SZ_HALF) && addr_q[0]) ||
                        ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
    assign err_w      = (size_q == 2'b11) || misalign_w || !in_range_w;
    assign idx_w      = offset_w[IDX_W+1:2];
    assign rd_word_w  = mem_q[idx_w];

    always_comb begin
        byte_w = rd_word_w[7:0];
        case (addr_q[1:0])
            2'd0:    byte_w = rd_word_w[7:0];
            2'd1:    byte_w = rd_word_w[15:8];
            2'd2:    byte_w = rd_word_w[23:16];
            default: byte_w = rd_word_w[31:24];
        endcase
        half_w = addr_q[1] ? rd_word_w[31:16] : rd_word_w[15:0];

        load_w = rd_word_w;
        case (size_q)
            SZ_BYTE: load_w = {{24{byte_w[7] & ~unsigned_q}}, byte_w};
            SZ_HALF: load_w = {{16{half_w[15] & ~unsigned_q}}, half_w};
            default: load_w = rd_word_w;
        endcase

        lane_mask_w = 32'hFFFF_FFFF;
        case (size_q)
            SZ_BYTE: lane_mask_w = 32'h0000_00FF << {addr_q[1:0], 3'b000};
            SZ_HALF: lane_mask_w = 32'h0000_FFFF << {addr_q[1], 4'b0000};
            default: lane_mask_w = 32'hFFFF_FFFF;
        endcase
        merged_w = (rd_word_w & ~lane_mask_w) |
                   ((wdata_q << {addr_q[1:0], 3'b000}) & lane_mask_w);
    end

    assign access_w = (state_q == S_BUSY) && (cnt_q == 4'd0);
    assign mem_we_w = access_w && write_q && !err_w;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    cnt_d      = LAT_LOAD;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = err_w;
                    rsp_rdata_d = (err_w || write_q) ? 32'h0 : load_w;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // Storage is deliberately outside the reset domain; a reset forces IDLE,
    // which already blocks any pending write.
    always_ff @(posedge clock) begin
        if (mem_we_w) begin
            mem_q[idx_w] <= merged_w;
        end
    end

    assign req_ready = reset && (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// Testbench for dmem_responder: directed scenarios plus randomized accesses
// checked against an arithmetic model of the memory.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h01000000;
    localparam int          LAT   = 2;
    localparam logic [31:0] LIMIT = BASE + 32'(4 * DEPTH);

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_mem [int];

    always #5 clock = ~clock;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    // Reference: little-endian word array, lanes selected by shift/mask arithmetic.
    function automatic void model(input logic [31:0] a, input logic w, input logic [1:0] s,
                                  input logic u, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        longint      al = longint'(a);
        int unsigned idx, sh;
        logic [31:0] mask, v;
        er = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00) ||
             (al < longint'(BASE)) || (al >= longint'(BASE) + 4 * longint'(DEPTH));
        rd = 32'h0;
        if (er) return;
        idx  = (a - BASE) / 4;
        sh   = (a % 4) * 8;
        mask = (s == 2'b00) ? 32'hFF : (s == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (!model_mem.exists(idx)) model_mem[idx] = 32'h0;
        v = model_mem[idx];
        if (w) begin
            model_mem[idx] = (v & ~(mask << sh)) | ((wd & mask) << sh);
        end else begin
            rd = (v >> sh) & mask;
            if (!u && s != 2'b10 && (rd & ((mask >> 1) + 1)) != 0) rd = rd | ~mask;
        end
    endfunction

    // Drives one request, scrambles request inputs after accept, waits (bounded)
    // for the response and acknowledges it. lat counts edges from accept to rsp_valid.
    task automatic do_txn(input logic [31:0] a, input logic w, input logic [1:0] s,
                          input logic u, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clock);
        req_addr = a; req_write = w; req_size = s; req_unsigned = u; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_write = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_wdata = $urandom;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (rsp_valid) break;
            lat++;
        end
        rd = rsp_rdata; er = rsp_error;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_data: got %h/%b want 0/0", rsp_rdata, rsp_error); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_word;
        logic [31:0] rd, mrd; logic er, mer; int lat;
        model(32'h01000010, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, mrd, mer);
        do_txn(32'h01000010, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw_resp: got %h/%b want 00000000/0", rd, er); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL sw_latency: got %0d want %0d", lat, LAT); end
        do_txn(32'h01000010, 1'b0, 2'b10, 1'b1, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_resp: got %h/%b want deadbeef/0", rd, er); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL lw_latency: got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_byte;
        logic [31:0] rd, mrd; logic er, mer; int lat;
        model(32'h01000013, 1'b1, 2'b00, 1'b0, 32'hABCDEF80, mrd, mer);
        do_txn(32'h01000013, 1'b1, 2'b00, 1'b0, 32'hABCDEF80, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sb_resp: got %h/%b want 00000000/0", rd, er); end
        do_txn(32'h01000013, 1'b0, 2'b00, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin errors++; $display("FAIL lb: got %h/%b want ffffff80/0", rd, er); end
        do_txn(32'h01000013, 1'b0, 2'b00, 1'b1, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h00000080 || er !== 1'b0) begin errors++; $display("FAIL lbu: got %h/%b want 00000080/0", rd, er); end
        do_txn(32'h01000012, 1'b0, 2'b01, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFF80AD) begin errors++; $display("FAIL lh_upper: got %h want ffff80ad", rd); end
        do_txn(32'h01000010, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h80ADBEEF) begin errors++; $display("FAIL lw_after_sb: got %h want 80adbeef", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat;
        do_txn(32'h01000011, 1'b0, 2'b01, 1'b0, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lh_misaligned: got %h/%b want 00000000/1", rd, er); end
        do_txn(32'h01000012, 1'b1, 2'b10, 1'b0, 32'h11223344, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL sw_misaligned: got %h/%b want 00000000/1", rd, er); end
        do_txn(32'h01000010, 1'b1, 2'b11, 1'b0, 32'h55667788, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL size_illegal: got %h/%b want 00000000/1", rd, er); end
        do_txn(32'h01000010, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h80ADBEEF || er !== 1'b0) begin errors++; $display("FAIL lw_after_errors: got %h/%b want 80adbeef/0", rd, er); end
    endtask

    task automatic test_range;
        logic [31:0] rd, mrd; logic er, mer; int lat;
        do_txn(32'h00FFFFFC, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL below_base: got %h/%b want 00000000/1", rd, er); end
        do_txn(LIMIT, 1'b1, 2'b10, 1'b0, 32'h01020304, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL at_limit: got err=%b want 1", er); end
        model(LIMIT - 4, 1'b1, 2'b10, 1'b0, 32'h0BADC0DE, mrd, mer);
        do_txn(LIMIT - 4, 1'b1, 2'b10, 1'b0, 32'h0BADC0DE, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_word_store: got err=%b want 0", er); end
        do_txn(LIMIT - 4, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'h0BADC0DE) begin errors++; $display("FAIL last_word_load: got %h/%b want 0badc0de/0", rd, er); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd, mrd, d0; logic er, mer, e0; int lat;
        model(32'h01000040, 1'b1, 2'b10, 1'b0, 32'hA5A55A5A, mrd, mer);
        do_txn(32'h01000040, 1'b1, 2'b10, 1'b0, 32'hA5A55A5A, rd, er, lat);
        @(negedge clock);
        req_addr = 32'h01000040; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_valid = 1'b1;
        @(posedge clock); #1 req_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (rsp_valid) break;
        end
        d0 = rsp_rdata; e0 = rsp_error;
        checks++; if (rsp_valid !== 1'b1 || d0 !== 32'hA5A55A5A || e0 !== 1'b0) begin errors++; $display("FAIL bp_first: got v=%b %h/%b want 1 a5a55a5a/0", rsp_valid, d0, e0); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                req_addr = 32'h01000040; req_write = 1'b1; req_size = 2'b10; req_wdata = 32'hFFFFFFFF;
                req_valid = 1'b1;
            end
            @(posedge clock); #1 req_valid = 1'b0;
            @(negedge clock);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== d0 || rsp_error !== e0 || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d: got v=%b %h/%b rdy=%b want 1 %h/%b rdy=0", i, rsp_valid, rsp_rdata, rsp_error, req_ready, d0, e0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1 rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v=%b rdy=%b want 0/1", rsp_valid, req_ready); end
        repeat (4) @(negedge clock);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_no_phantom: got v=%b want 0", rsp_valid); end
        do_txn(32'h01000040, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hA5A55A5A) begin errors++; $display("FAIL bp_store_ignored: got %h want a5a55a5a", rd); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd, mrd; logic er, mer; int lat;
        model(32'h01000020, 1'b1, 2'b10, 1'b0, 32'hCAFEF00D, mrd, mer);
        do_txn(32'h01000020, 1'b1, 2'b10, 1'b0, 32'hCAFEF00D, rd, er, lat);
        @(negedge clock);
        req_addr = 32'h01000020; req_write = 1'b1; req_size = 2'b10; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clock); #1 req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL busy_reset: got v=%b rdy=%b want 0/0", rsp_valid, req_ready); end
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL busy_reset_release: got rdy=%b want 1", req_ready); end
        do_txn(32'h01000020, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin errors++; $display("FAIL store_dropped: got %h/%b want cafef00d/0", rd, er); end
        // Reset while a response is pending must clear it without waiting for an edge.
        @(negedge clock);
        req_addr = 32'h01000020; req_write = 1'b0; req_size = 2'b10; req_valid = 1'b1;
        @(posedge clock); #1 req_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (rsp_valid) break;
        end
        #1 reset = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL resp_reset_async: got v=%b %h want 0 00000000", rsp_valid, rsp_rdata); end
        @(negedge clock) reset = 1'b1;
        @(negedge clock);
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL resp_reset_after: got v=%b rdy=%b want 0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_random;
        logic [31:0] rd, mrd, a, wd; logic er, mer, w, u; logic [1:0] s; int lat;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            model(32'h01000100 + 32'(4 * i), 1'b1, 2'b10, 1'b0, wd, mrd, mer);
            do_txn(32'h01000100 + 32'(4 * i), 1'b1, 2'b10, 1'b0, wd, rd, er, lat);
        end
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0:       a = BASE - 32'($urandom_range(1, 64));
                1:       a = LIMIT + 32'($urandom_range(0, 64));
                default: a = 32'h01000100 + 32'($urandom_range(0, 63));
            endcase
            w = 1'($urandom); u = 1'($urandom); wd = $urandom;
            s = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            model(a, w, s, u, wd, mrd, mer);
            do_txn(a, w, s, u, wd, rd, er, lat);
            checks++;
            if (rd !== mrd || er !== mer || lat != LAT) begin
                errors++; $display("FAIL rand_%0d a=%h w=%b s=%b u=%b: got %h/%b lat=%0d want %h/%b lat=%0d", i, a, w, s, u, rd, er, lat, mrd, mer, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_errors();
        test_range();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
